// File: rtl/syscall_ctrl_if.sv
// Peripheral side of the syscall controller: memory request port, console byte
// stream and VGA command port. The controller uses the master view.
interface syscall_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        vid_activate;
  logic        vid_clear;
  logic        vid_write;
  logic [15:0] vid_addr;
  logic [15:0] vid_data;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output con_valid, con_data,
    input  con_ready,
    output vid_activate, vid_clear, vid_write, vid_addr, vid_data
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  con_valid, con_data,
    output con_ready,
    input  vid_activate, vid_clear, vid_write, vid_addr, vid_data
  );
endinterface

// File: rtl/syscall_ctrl.sv
// Syscall service controller: latches a request on the CPU strobe's rising edge
// and performs memory, console-print and VGA operations selected by the code.
module syscall_ctrl #(
  parameter int MAX_STR = 256
) (
  input  logic           clk,
  input  logic           clear_n,
  input  logic           sys_signal,
  input  logic [47:0]    sysregs,
  output logic           busy,
  output logic           done,
  output logic           halt,
  output logic           load_signal,
  output logic [15:0]    load_data,
  syscall_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(MAX_STR + 1);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] DISPATCH = 4'd1;
  localparam logic [3:0] MEM      = 4'd2;
  localparam logic [3:0] CHAR     = 4'd3;
  localparam logic [3:0] DEC      = 4'd4;
  localparam logic [3:0] STR_RD   = 4'd5;
  localparam logic [3:0] STR_OUT  = 4'd6;
  localparam logic [3:0] VID      = 4'd7;
  localparam logic [3:0] DONE     = 4'd8;
  localparam logic [3:0] HALT     = 4'd9;

  logic [3:0]       state_q, state_d;
  logic             sig_q, armed_q;
  logic [15:0]      code_q, code_d, arg0_q, arg0_d, arg1_q, arg1_d;
  logic             halt_q, halt_d, load_signal_q, load_signal_d;
  logic [15:0]      load_data_q, load_data_d;
  logic             con_valid_q, con_valid_d;
  logic [7:0]       con_data_q, con_data_d;
  logic [15:0]      vid_addr_q, vid_addr_d, vid_data_q, vid_data_d;
  logic [15:0]      ptr_q, ptr_d, rem_q, rem_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       digit_q, digit_d;
  logic             lead_q, lead_d;
  logic             accept, blank;

  function automatic logic [15:0] dec_pow(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'd10000;
      3'd1:    return 16'd1000;
      3'd2:    return 16'd100;
      3'd3:    return 16'd10;
      default: return 16'd1;
    endcase
  endfunction

  function automatic logic [7:0] dec_char(input logic [3:0] digit, input logic is_blank);
    return is_blank ? 8'h20 : (8'h30 + {4'h0, digit});
  endfunction

  // armed_q masks the first cycle after reset so a strobe already high is not an edge
  assign accept = armed_q && sys_signal && !sig_q && (state_q == IDLE);
  assign blank  = (digit_q == 4'd0) && !lead_q && (idx_q != 3'd4);

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    arg0_d        = arg0_q;
    arg1_d        = arg1_q;
    halt_d        = halt_q;
    load_signal_d = load_signal_q;
    load_data_d   = load_data_q;
    con_valid_d   = con_valid_q;
    con_data_d    = con_data_q;
    vid_addr_d    = vid_addr_q;
    vid_data_d    = vid_data_q;
    ptr_d         = ptr_q;
    rem_d         = rem_q;
    scnt_d        = scnt_q;
    idx_d         = idx_q;
    digit_d       = digit_q;
    lead_d        = lead_q;
    case (state_q)
      IDLE: if (accept) begin
        code_d  = sysregs[15:0];
        arg0_d  = sysregs[31:16];
        arg1_d  = sysregs[47:32];
        state_d = DISPATCH;
      end
      DISPATCH: begin
        if (code_q != 16'd2) load_signal_d = 1'b0;
        case (code_q)
          16'd0: begin halt_d = 1'b1; state_d = HALT; end
          16'd1, 16'd2: state_d = MEM;
          16'd3: begin
            rem_d = arg0_q; idx_d = 3'd0; digit_d = 4'd0; lead_d = 1'b0;
            state_d = DEC;
          end
          16'd4: begin con_valid_d = 1'b1; con_data_d = arg0_q[7:0]; state_d = CHAR; end
          16'd5: begin
            ptr_d = arg0_q; scnt_d = '0;
            state_d = (MAX_STR > 0) ? STR_RD : DONE;
          end
          16'd6, 16'd7: state_d = VID;
          16'd8: begin vid_addr_d = arg0_q; vid_data_d = arg1_q; state_d = VID; end
          default: state_d = DONE;
        endcase
      end
      MEM: if (bus.mem_ack) begin
        if (code_q == 16'd2) begin
          load_data_d   = bus.mem_rdata;
          load_signal_d = 1'b1;
        end
        state_d = DONE;
      end
      CHAR: if (bus.con_ready) begin con_valid_d = 1'b0; state_d = DONE; end
      // One subtraction per cycle; the byte is offered once the power no longer fits
      DEC: begin
        if (con_valid_q) begin
          if (bus.con_ready) begin
            con_valid_d = 1'b0;
            digit_d     = 4'd0;
            if (idx_q == 3'd4) state_d = DONE;
            else               idx_d   = idx_q + 3'd1;
          end
        end else if (rem_q >= dec_pow(idx_q)) begin
          rem_d   = rem_q - dec_pow(idx_q);
          digit_d = digit_q + 4'd1;
        end else begin
          con_valid_d = 1'b1;
          con_data_d  = dec_char(digit_q, blank);
          if (!blank) lead_d = 1'b1;
        end
      end
      STR_RD: if (bus.mem_ack) begin
        if (bus.mem_rdata == 16'd0) state_d = DONE;
        else begin
          con_valid_d = 1'b1;
          con_data_d  = bus.mem_rdata[7:0];
          ptr_d       = ptr_q + 16'd1;
          scnt_d      = scnt_q + CNT_W'(1);
          state_d     = STR_OUT;
        end
      end
      STR_OUT: if (bus.con_ready) begin
        con_valid_d = 1'b0;
        state_d     = (scnt_q == CNT_W'(MAX_STR)) ? DONE : STR_RD;
      end
      VID:     state_d = DONE;
      DONE:    state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= IDLE;
      sig_q         <= 1'b0;
      armed_q       <= 1'b0;
      code_q        <= '0;
      arg0_q        <= '0;
      arg1_q        <= '0;
      halt_q        <= 1'b0;
      load_signal_q <= 1'b0;
      load_data_q   <= '0;
      con_valid_q   <= 1'b0;
      con_data_q    <= '0;
      vid_addr_q    <= '0;
      vid_data_q    <= '0;
      ptr_q         <= '0;
      rem_q         <= '0;
      scnt_q        <= '0;
      idx_q         <= '0;
      digit_q       <= '0;
      lead_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sig_q         <= sys_signal;
      armed_q       <= 1'b1;
      code_q        <= code_d;
      arg0_q        <= arg0_d;
      arg1_q        <= arg1_d;
      halt_q        <= halt_d;
      load_signal_q <= load_signal_d;
      load_data_q   <= load_data_d;
      con_valid_q   <= con_valid_d;
      con_data_q    <= con_data_d;
      vid_addr_q    <= vid_addr_d;
      vid_data_q    <= vid_data_d;
      ptr_q         <= ptr_d;
      rem_q         <= rem_d;
      scnt_q        <= scnt_d;
      idx_q         <= idx_d;
      digit_q       <= digit_d;
      lead_q        <= lead_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign halt        = halt_q;
  assign load_signal = load_signal_q;
  assign load_data   = load_data_q;

  assign bus.mem_req      = (state_q == MEM) || (state_q == STR_RD);
  assign bus.mem_we       = (state_q == MEM) && (code_q == 16'd1);
  assign bus.mem_addr     = (state_q == MEM) ? arg0_q : ((state_q == STR_RD) ? ptr_q : 16'd0);
  assign bus.mem_wdata    = bus.mem_we ? arg1_q : 16'd0;
  assign bus.con_valid    = con_valid_q;
  assign bus.con_data     = con_data_q;
  assign bus.vid_activate = (state_q == VID) && (code_q == 16'd6);
  assign bus.vid_clear    = (state_q == VID) && (code_q == 16'd7);
  assign bus.vid_write    = (state_q == VID) && (code_q == 16'd8);
  assign bus.vid_addr     = vid_addr_q;
  assign bus.vid_data     = vid_data_q;

endmodule

// File: tb/tb_syscall_ctrl.sv
// Bench for syscall_ctrl: memory responder, console sink and monitors run on the
// falling edge; each task issues syscalls and compares against a reference model.
module tb_syscall_ctrl;
  localparam int MAX_STR = 256;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        sys_signal = 1'b0;
  logic [47:0] sysregs = '0;
  logic        busy, done, halt, load_signal;
  logic [15:0] load_data;

  syscall_ctrl_if bus();

  syscall_ctrl #(.MAX_STR(MAX_STR)) dut (
    .clk(clk), .clear_n(clear_n), .sys_signal(sys_signal), .sysregs(sysregs),
    .busy(busy), .done(done), .halt(halt), .load_signal(load_signal),
    .load_data(load_data), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  byte         con_q[$];
  int ack_delay = 0, ack_wait = 0, ready_mode = 0;
  int writes = 0, wreq_cycles = 0, req_cycles = 0, done_cnt = 0;
  int vact_cnt = 0, vclr_cnt = 0, vwr_cnt = 0;
  int overlap_err = 0, stab_err = 0, multi_vid = 0;
  logic       prev_valid = 1'b0, prev_xfer = 1'b0;
  logic [7:0] prev_data = '0;
  int checks = 0, errors = 0;

  logic [97:0] all_out;
  assign all_out = {busy, done, halt, load_signal, load_data, bus.mem_req, bus.mem_we,
                    bus.mem_addr, bus.mem_wdata, bus.con_valid, bus.con_data,
                    bus.vid_activate, bus.vid_clear, bus.vid_write, bus.vid_addr, bus.vid_data};

  // Memory responder, console sink and protocol monitors
  always @(negedge clk) begin
    if (bus.mem_req && !bus.mem_ack) begin
      if (ack_wait >= ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr];
        if (bus.mem_we) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          writes++;
        end
      end else ack_wait++;
    end else begin
      bus.mem_ack = 1'b0;
      ack_wait    = 0;
    end
    if (bus.mem_req) req_cycles++;
    if (bus.mem_req && bus.mem_we) wreq_cycles++;
    case (ready_mode)
      0:       bus.con_ready = 1'b1;
      1:       bus.con_ready = ~bus.con_ready;
      default: bus.con_ready = 1'($urandom_range(0, 1));
    endcase
    if (bus.con_valid && prev_valid && !prev_xfer && bus.con_data !== prev_data) stab_err++;
    prev_valid = bus.con_valid;
    prev_data  = bus.con_data;
    prev_xfer  = bus.con_valid && bus.con_ready;
    if (prev_xfer) con_q.push_back(bus.con_data);
    if (bus.mem_req && bus.con_valid) overlap_err++;
    if (int'(bus.vid_activate) + int'(bus.vid_clear) + int'(bus.vid_write) > 1) multi_vid++;
    if (bus.vid_activate) vact_cnt++;
    if (bus.vid_clear) vclr_cnt++;
    if (bus.vid_write) vwr_cnt++;
    if (done) done_cnt++;
  end

  function automatic string q2s();
    string s = "";
    foreach (con_q[i]) s = $sformatf("%s%c", s, con_q[i]);
    return s;
  endfunction

  // Reference for code 5: walk memory until a zero word or the length cap
  function automatic string str_ref(input logic [15:0] a);
    string s = "";
    logic [15:0] p = a;
    logic [15:0] w;
    for (int n = 0; n < MAX_STR; n++) begin
      w = mem[p];
      if (w == 16'd0) break;
      s = $sformatf("%s%c", s, w[7:0]);
      p = p + 16'd1;
    end
    return s;
  endfunction

  task automatic issue(input logic [15:0] code, input logic [15:0] a0, input logic [15:0] a1);
    @(negedge clk);
    sysregs    = {a1, a0, code};
    sys_signal = 1'b1;
    @(negedge clk);
    sys_signal = 1'b0;
    sysregs    = {16'($urandom), 16'($urandom), 16'($urandom)};
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs got %h required 0", all_out);
    end
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || halt !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%b halt=%b required 0 0", busy, halt);
    end
  endtask

  task automatic test_mem_write();
    int w0 = writes, r0 = wreq_cycles, d0 = done_cnt;
    bit ok;
    ack_delay = 2;
    issue(16'd1, 16'h0010, 16'hBEEF);
    wait_done(50, ok);
    checks++;
    if (!ok || mem[16'h0010] !== 16'hBEEF || writes - w0 != 1) begin
      errors++; $display("FAIL mem_write ok=%0b mem=%h writes=%0d required BEEF 1", ok, mem[16'h0010], writes - w0);
    end
    checks++;
    if (wreq_cycles - r0 != 3 || done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL mem_write_timing req_cycles=%0d dones=%0d busy=%b required 3 1 0", wreq_cycles - r0, done_cnt - d0, busy);
    end
    ack_delay = 0;
  endtask

  task automatic test_mem_read();
    bit ok;
    ack_delay = 1;
    issue(16'd2, 16'h0010, 16'h0000);
    wait_done(50, ok);
    checks++;
    if (!ok || load_data !== 16'hBEEF || load_signal !== 1'b1) begin
      errors++; $display("FAIL mem_read ok=%0b load_data=%h load_signal=%b required BEEF 1", ok, load_data, load_signal);
    end
    con_q.delete();
    issue(16'd4, 16'h1241, 16'h0000);
    wait_done(50, ok);
    checks++;
    if (!ok || load_signal !== 1'b0 || q2s() != "A") begin
      errors++; $display("FAIL load_clear ok=%0b load_signal=%b bytes=\"%s\" required 0 \"A\"", ok, load_signal, q2s());
    end
    ack_delay = 0;
  endtask

  task automatic test_dec();
    logic [15:0] vals[$] = '{16'd42, 16'd0, 16'd9, 16'd10, 16'd99, 16'd100, 16'd10000, 16'd65535};
    bit ok;
    string exp;
    for (int k = 0; k < 5; k++) vals.push_back(16'($urandom));
    foreach (vals[i]) begin
      ready_mode = (i == 0) ? 1 : 2;
      con_q.delete();
      issue(16'd3, vals[i], 16'($urandom));
      wait_done(400, ok);
      exp = $sformatf("%5d", int'(vals[i]));
      checks++;
      if (!ok || q2s() != exp) begin
        errors++; $display("FAIL dec_%0d ok=%0b got \"%s\" required \"%s\"", vals[i], ok, q2s(), exp);
      end
    end
    ready_mode = 0;
  endtask

  task automatic test_string();
    bit ok;
    string exp;
    logic [15:0] a, p;
    int len;
    mem[16'hFFFF] = 16'h0048;
    mem[16'h0000] = 16'h0069;
    mem[16'h0001] = 16'h0000;
    ready_mode = 1;
    con_q.delete();
    issue(16'd5, 16'hFFFF, 16'h0000);
    wait_done(100, ok);
    checks++;
    if (!ok || q2s() != "Hi") begin
      errors++; $display("FAIL str_wrap ok=%0b got \"%s\" required \"Hi\"", ok, q2s());
    end
    ready_mode = 2;
    for (int t = 0; t < 4; t++) begin
      a = 16'($urandom_range(16'h0100, 16'h7000));
      len = $urandom_range(1, 20);
      p = a;
      for (int k = 0; k < len; k++) begin
        mem[p] = {8'($urandom), 8'($urandom_range(33, 126))};
        p = p + 16'd1;
      end
      mem[p] = 16'h0000;
      exp = str_ref(a);
      con_q.delete();
      ack_delay = $urandom_range(0, 2);
      issue(16'd5, a, 16'h0000);
      wait_done(500, ok);
      checks++;
      if (!ok || q2s() != exp) begin
        errors++; $display("FAIL str_rand_%0d ok=%0b got \"%s\" required \"%s\"", t, ok, q2s(), exp);
      end
    end
    ack_delay = 0;
    ready_mode = 0;
    p = 16'h8000;
    for (int k = 0; k < 300; k++) begin
      mem[p] = {8'h00, 8'($urandom_range(33, 126))};
      p = p + 16'd1;
    end
    exp = str_ref(16'h8000);
    con_q.delete();
    issue(16'd5, 16'h8000, 16'h0000);
    wait_done(3000, ok);
    checks++;
    if (!ok || con_q.size() != MAX_STR || q2s() != exp) begin
      errors++; $display("FAIL str_max ok=%0b bytes=%0d required %0d", ok, con_q.size(), MAX_STR);
    end
  endtask

  task automatic test_vid();
    int wr0 = vwr_cnt, ac0 = vact_cnt, cl0 = vclr_cnt, d0 = done_cnt;
    bit ok;
    @(negedge clk);
    sysregs = {16'h0041, 16'h0005, 16'd8};
    sys_signal = 1'b1;
    @(negedge clk);
    sys_signal = 1'b0;
    @(negedge clk);
    sysregs = {16'h0000, 16'h0000, 16'd6};
    sys_signal = 1'b1;
    repeat (6) @(negedge clk);
    sys_signal = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (vwr_cnt - wr0 != 1 || vact_cnt - ac0 != 0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL vid_write writes=%0d activates=%0d dones=%0d required 1 0 1", vwr_cnt - wr0, vact_cnt - ac0, done_cnt - d0);
    end
    checks++;
    if (bus.vid_addr !== 16'h0005 || bus.vid_data !== 16'h0041) begin
      errors++; $display("FAIL vid_regs addr=%h data=%h required 0005 0041", bus.vid_addr, bus.vid_data);
    end
    issue(16'd6, 16'h1111, 16'h2222);
    wait_done(20, ok);
    issue(16'd7, 16'h3333, 16'h4444);
    wait_done(20, ok);
    checks++;
    if (!ok || vact_cnt - ac0 != 1 || vclr_cnt - cl0 != 1 || vwr_cnt - wr0 != 1 || bus.vid_addr !== 16'h0005) begin
      errors++; $display("FAIL vid_strobes act=%0d clr=%0d wr=%0d addr=%h required 1 1 1 0005", vact_cnt - ac0, vclr_cnt - cl0, vwr_cnt - wr0, bus.vid_addr);
    end
  endtask

  task automatic test_other_codes();
    bit ok;
    logic [15:0] codes[2];
    codes[0] = 16'($urandom_range(9, 65535));
    codes[1] = 16'hFFFF;
    foreach (codes[i]) begin
      int w0 = writes, r0 = req_cycles, v0 = vact_cnt + vclr_cnt + vwr_cnt;
      con_q.delete();
      issue(codes[i], 16'($urandom), 16'($urandom));
      wait_done(20, ok);
      checks++;
      if (!ok || writes != w0 || req_cycles != r0 || con_q.size() != 0 || vact_cnt + vclr_cnt + vwr_cnt != v0) begin
        errors++; $display("FAIL code_%0d ok=%0b side_effects mem=%0d bytes=%0d required none", codes[i], ok, req_cycles - r0, con_q.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    int w0 = writes, d0 = done_cnt;
    bit ok1, ok2;
    con_q.delete();
    issue(16'd4, 16'h0031, 16'h0000);
    wait_done(20, ok1);
    issue(16'd4, 16'h0032, 16'h0000);
    wait_done(20, ok2);
    checks++;
    if (!ok1 || !ok2 || q2s() != "12") begin
      errors++; $display("FAIL back_to_back got \"%s\" required \"12\"", q2s());
    end
    // New edge lands on the same edge the write acknowledge is consumed
    d0 = done_cnt;
    ack_delay = 0;
    @(negedge clk);
    sysregs = {16'h1234, 16'h0020, 16'd1};
    sys_signal = 1'b1;
    @(negedge clk);
    sys_signal = 1'b0;
    @(negedge clk);
    sys_signal = 1'b1;
    repeat (5) @(negedge clk);
    sys_signal = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (writes - w0 != 1 || done_cnt - d0 != 1 || busy !== 1'b0 || mem[16'h0020] !== 16'h1234) begin
      errors++; $display("FAIL ack_edge_collision writes=%0d dones=%0d busy=%b required 1 1 0", writes - w0, done_cnt - d0, busy);
    end
  endtask

  task automatic test_halt_reset();
    int d0 = done_cnt, qn;
    bit ok;
    logic [15:0] p;
    issue(16'd0, 16'h0000, 16'h0000);
    repeat (20) @(negedge clk);
    con_q.delete();
    issue(16'd4, 16'h0041, 16'h0000);
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (halt !== 1'b1 || done_cnt != d0 || con_q.size() != 0) begin
      errors++; $display("FAIL halt_sticky halt=%b dones=%0d bytes=%0d required 1 0 0", halt, done_cnt - d0, con_q.size());
    end
    @(posedge clk); #1;
    clear_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL halt_reset got %h required 0", all_out);
    end
    @(negedge clk);
    clear_n = 1'b1;
    p = 16'h3000;
    for (int k = 0; k < 40; k++) begin
      mem[p] = 16'h0061 + 16'(k % 20);
      p = p + 16'd1;
    end
    mem[p] = 16'h0000;
    ready_mode = 2;
    con_q.delete();
    issue(16'd5, 16'h3000, 16'h0000);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (con_q.size() >= 3) break;
    end
    @(posedge clk); #1;
    clear_n = 1'b0;
    sys_signal = 1'b1;
    #1;
    checks++;
    if (all_out !== '0 || con_q.size() < 3) begin
      errors++; $display("FAIL midop_reset got %h bytes=%0d required 0 and >=3", all_out, con_q.size());
    end
    qn = con_q.size();
    d0 = done_cnt;
    @(negedge clk);
    clear_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done_cnt != d0 || con_q.size() != qn) begin
      errors++; $display("FAIL release_no_edge busy=%b dones=%0d extra_bytes=%0d required 0 0 0", busy, done_cnt - d0, con_q.size() - qn);
    end
    sys_signal = 1'b0;
    ready_mode = 0;
    con_q.delete();
    issue(16'd4, 16'h005A, 16'h0000);
    wait_done(20, ok);
    checks++;
    if (!ok || q2s() != "Z") begin
      errors++; $display("FAIL after_reset ok=%0b got \"%s\" required \"Z\"", ok, q2s());
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (overlap_err != 0 || stab_err != 0 || multi_vid != 0) begin
      errors++; $display("FAIL invariants overlap=%0d unstable=%0d multi_vid=%0d required 0 0 0", overlap_err, stab_err, multi_vid);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    bus.con_ready = 1'b0;
    test_reset();
    test_mem_write();
    test_mem_read();
    test_dec();
    test_string();
    test_vid();
    test_other_codes();
    test_back_to_back();
    test_halt_reset();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
